// File: rtl/ahb2_rr_arbiter_if.sv
// Bus-side signal bundle for ahb2_rr_arbiter: request/lock/transfer inputs and grant/owner outputs.
// The master modport is taken by the arbiter; the slave modport is for the fabric that consumes the grant.
interface ahb2_rr_arbiter_if #(
  parameter int MASTER_CNT      = 2,
  parameter int MASTER_ID_WIDTH = $clog2(MASTER_CNT)
);
  logic                       hready_i;
  logic [1:0]                 htrans_i;
  logic [MASTER_CNT-1:0]      hbusreq_vec_i;
  logic [MASTER_CNT-1:0]      hlock_vec_i;
  logic [MASTER_CNT-1:0]      hgrant_vec_o;
  logic [MASTER_ID_WIDTH-1:0] hmaster_o;
  logic [MASTER_ID_WIDTH-1:0] hmaster_data_o;
  logic                       hmastlock_o;

  modport master (
    input  hready_i, htrans_i, hbusreq_vec_i, hlock_vec_i,
    output hgrant_vec_o, hmaster_o, hmaster_data_o, hmastlock_o
  );

  modport slave (
    output hready_i, htrans_i, hbusreq_vec_i, hlock_vec_i,
    input  hgrant_vec_o, hmaster_o, hmaster_data_o, hmastlock_o
  );
endinterface

// File: rtl/ahb2_rr_arbiter.sv
// Round-robin AHB2 arbiter with hlock support, burst holding and parking on DEFAULT_MST.
// Optional beat-limited burst hold is enabled by defining AHB2_ARB_MAXHOLD_EN.
module ahb2_rr_arbiter #(
  parameter int MASTER_CNT      = 2,
  parameter int MASTER_ID_WIDTH = $clog2(MASTER_CNT),
  parameter int DEFAULT_MST     = 0,
  parameter int MAX_HOLD        = 16
) (
  input  logic clk,
  input  logic rst_n,
  ahb2_rr_arbiter_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [MASTER_ID_WIDTH-1:0] DEFAULT_ID    = MASTER_ID_WIDTH'(DEFAULT_MST);
  localparam logic [MASTER_CNT-1:0]      DEFAULT_GRANT = MASTER_CNT'(1) << DEFAULT_MST;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                     state_reg, state_next;
  logic [MASTER_CNT-1:0]      hgrant_reg, hgrant_next;
  logic [MASTER_ID_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [MASTER_ID_WIDTH-1:0] hmaster_reg;
  logic [MASTER_ID_WIDTH-1:0] hmaster_data_reg;
  logic                       hmastlock_reg;

  logic [MASTER_ID_WIDTH-1:0] owner_idx;
  logic                       owner_lock;
  logic [2*MASTER_CNT-1:0]    req_dbl;
  logic [MASTER_CNT-1:0]      req_rot;
  logic                       winner_vld;
  logic [MASTER_ID_WIDTH-1:0] winner_idx;
  int                         rot_pos;
  int                         win_sum;
  logic                       trans_boundary;
  logic                       arb_open;
  logic                       rearb;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < MASTER_CNT; i++) begin
      if (hgrant_reg[i]) owner_idx = owner_idx | MASTER_ID_WIDTH'(i);
    end
  end

  assign owner_lock     = bus.hlock_vec_i[owner_idx];
  assign trans_boundary = (bus.htrans_i == HTRANS_IDLE) || (bus.htrans_i == HTRANS_NONSEQ);

  // Requests rotated so bit 0 is the master just after the RR pointer; the
  // owner itself lands in the top bit and therefore only wins when alone.
  assign req_dbl = {bus.hbusreq_vec_i, bus.hbusreq_vec_i};
  assign req_rot = MASTER_CNT'(req_dbl >> (32'(rr_ptr_reg) + 32'd1));

  always_comb begin
    winner_vld = |bus.hbusreq_vec_i;
    rot_pos    = 0;
    for (int k = MASTER_CNT - 1; k >= 0; k--) begin
      if (req_rot[k]) rot_pos = k;
    end
    win_sum = int'(rr_ptr_reg) + 1 + rot_pos;
    if (win_sum >= MASTER_CNT) win_sum = win_sum - MASTER_CNT;
    winner_idx = MASTER_ID_WIDTH'(win_sum);
  end

`ifdef AHB2_ARB_MAXHOLD_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] beat_cnt_reg;
  logic              hold_expired;
  logic              other_req;

  assign hold_expired = (beat_cnt_reg == HOLD_W'(MAX_HOLD - 1));
  assign other_req    = |(bus.hbusreq_vec_i & ~hgrant_reg);
  assign arb_open     = trans_boundary || (hold_expired && other_req);

  // Saturates at the limit; a fresh owner always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_reg <= '0;
    end else if (bus.hready_i) begin
      if (hgrant_next != hgrant_reg) begin
        beat_cnt_reg <= '0;
      end else if (bus.htrans_i[1] && !hold_expired) begin
        beat_cnt_reg <= beat_cnt_reg + HOLD_W'(1);
      end
    end
  end
`else
  assign arb_open = trans_boundary;
`endif

  always_comb begin
    state_next  = state_reg;
    hgrant_next = hgrant_reg;
    rr_ptr_next = rr_ptr_reg;
    rearb       = 1'b0;
    if (bus.hready_i) begin
      case (state_reg)
        ST_IDLE: rearb = 1'b1;
        ST_GRANT: begin
          if (arb_open) begin
            if (owner_lock) state_next = ST_LOCKED;
            else            rearb      = 1'b1;
          end
        end
        ST_LOCKED: begin
          // Once hlock drops, the in-flight transfer finishes under GRANT rules.
          if (!owner_lock) begin
            if (arb_open) rearb      = 1'b1;
            else          state_next = ST_GRANT;
          end
        end
        default: state_next = ST_IDLE;
      endcase
      if (rearb) begin
        if (winner_vld) begin
          hgrant_next = MASTER_CNT'(1) << winner_idx;
          rr_ptr_next = winner_idx;
          state_next  = ST_GRANT;
        end else begin
          hgrant_next = DEFAULT_GRANT;
          rr_ptr_next = DEFAULT_ID;
          state_next  = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      hgrant_reg       <= DEFAULT_GRANT;
      rr_ptr_reg       <= DEFAULT_ID;
      hmaster_reg      <= DEFAULT_ID;
      hmaster_data_reg <= DEFAULT_ID;
      hmastlock_reg    <= 1'b0;
    end else if (bus.hready_i) begin
      state_reg        <= state_next;
      hgrant_reg       <= hgrant_next;
      rr_ptr_reg       <= rr_ptr_next;
      hmaster_reg      <= owner_idx;
      hmaster_data_reg <= hmaster_reg;
      hmastlock_reg    <= owner_lock;
    end
  end

  assign bus.hgrant_vec_o   = hgrant_reg;
  assign bus.hmaster_o      = hmaster_reg;
  assign bus.hmaster_data_o = hmaster_data_reg;
  assign bus.hmastlock_o    = hmastlock_reg;

endmodule

// File: tb/tb_ahb2_rr_arbiter.sv
// Bench for ahb2_rr_arbiter (3 masters): directed scenarios followed by random traffic,
// every cycle compared against a transfer-level reference model of the arbitration rules.
module tb_ahb2_rr_arbiter;

  localparam int MC   = 3;
  localparam int IDW  = 2;
  localparam int DEF  = 0;
  localparam int MAXH = 4;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
`ifdef AHB2_ARB_MAXHOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;

  // reference model: owner, mode (0 parked, 1 holding, 2 locked), pipelined owners
  int m_owner, m_mode, m_hmaster, m_hdata, m_cnt;
  bit m_lock;

  ahb2_rr_arbiter_if #(.MASTER_CNT(MC), .MASTER_ID_WIDTH(IDW)) bus ();

  ahb2_rr_arbiter #(
    .MASTER_CNT(MC), .MASTER_ID_WIDTH(IDW), .DEFAULT_MST(DEF), .MAX_HOLD(MAXH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] onehot(input int i);
    return 32'd1 << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = DEF; m_mode = 0; m_hmaster = DEF; m_hdata = DEF; m_lock = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int own, nxt, cand;
    bit lk, open, arb;
    if (!rst_n || !bus.hready_i) return;
    own  = m_owner;
    lk   = bus.hlock_vec_i[own];
    open = (bus.htrans_i == T_IDLE) || (bus.htrans_i == T_NSEQ);
    if (HOLD_EN && m_cnt >= MAXH - 1 && (bus.hbusreq_vec_i & ~MC'(onehot(own))) != '0) open = 1;
    arb = 0;
    if (m_mode == 0) arb = 1;
    else if (!(m_mode == 2 && lk)) begin
      m_mode = 1;
      if (open) begin
        if (lk) m_mode = 2;
        else    arb = 1;
      end
    end
    nxt = own;
    if (arb) begin
      nxt = DEF;
      m_mode = 0;
      for (int k = 1; k <= MC; k++) begin
        cand = (own + k) % MC;
        if (bus.hbusreq_vec_i[cand]) begin
          nxt = cand;
          m_mode = 1;
          break;
        end
      end
    end
    if (nxt != own) m_cnt = 0;
    else if (bus.htrans_i[1]) m_cnt++;
    m_hdata   = m_hmaster;
    m_hmaster = own;
    m_lock    = lk;
    m_owner   = nxt;
  endtask

  task automatic drive(input logic rdy, input logic [1:0] tr,
                       input logic [MC-1:0] req, input logic [MC-1:0] lock);
    bus.hready_i      = rdy;
    bus.htrans_i      = tr;
    bus.hbusreq_vec_i = req;
    bus.hlock_vec_i   = lock;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".grant"},   32'(bus.hgrant_vec_o),   onehot(m_owner));
    chk({tag, ".hmaster"}, 32'(bus.hmaster_o),      32'(m_hmaster));
    chk({tag, ".hdata"},   32'(bus.hmaster_data_o), 32'(m_hdata));
    chk({tag, ".mlock"},   32'(bus.hmastlock_o),    32'(m_lock));
  endtask

  initial begin
    drive(1'b1, T_IDLE, 3'b000, 3'b000);
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset.grant",   32'(bus.hgrant_vec_o),   32'h1);
    chk("reset.hmaster", 32'(bus.hmaster_o),      32'h0);
    chk("reset.hdata",   32'(bus.hmaster_data_o), 32'h0);
    chk("reset.mlock",   32'(bus.hmastlock_o),    32'h0);
    repeat (2) cyc("rst");
    rst_n = 1'b1;

    // 1: idle bus parks on the default master
    repeat (2) cyc("park");
    chk("park.grant", 32'(bus.hgrant_vec_o), 32'h1);

    // 2: single request, grant then hmaster then hmaster_data
    drive(1'b1, T_IDLE, 3'b010, 3'b000);
    cyc("req1");
    chk("req1.grant", 32'(bus.hgrant_vec_o), 32'h2);
    chk("req1.hmaster_old", 32'(bus.hmaster_o), 32'h0);
    cyc("req1b");
    chk("req1.hmaster", 32'(bus.hmaster_o), 32'h1);
    chk("req1.hdata_old", 32'(bus.hmaster_data_o), 32'h0);
    cyc("req1c");
    chk("req1.hdata", 32'(bus.hmaster_data_o), 32'h1);
    drive(1'b1, T_IDLE, 3'b000, 3'b000);
    cyc("drop1");
    chk("drop1.grant", 32'(bus.hgrant_vec_o), 32'h1);

    // 3: everyone requesting, single transfers -> 1,2,0,1,2,0
    drive(1'b1, T_NSEQ, 3'b111, 3'b000);
    for (int i = 0; i < 6; i++) begin
      cyc("rr");
      chk("rr.order", 32'(bus.hgrant_vec_o), onehot((i + 1) % 3));
    end
    drive(1'b1, T_IDLE, 3'b000, 3'b000);
    cyc("rr_end");

    // 4: M0 INCR4, M1 waits for the burst to end
    drive(1'b1, T_IDLE, 3'b001, 3'b000);
    cyc("b4_req");
    chk("b4.grant0", 32'(bus.hgrant_vec_o), 32'h1);
    drive(1'b1, T_NSEQ, 3'b001, 3'b000);
    cyc("b4_nseq");
    drive(1'b1, T_SEQ, 3'b011, 3'b000);
    for (int j = 0; j < 3; j++) begin
      cyc("b4_seq");
      chk("b4.hold", 32'(bus.hgrant_vec_o), (HOLD_EN && j == 2) ? 32'h2 : 32'h1);
    end
    drive(1'b1, T_IDLE, 3'b011, 3'b000);
    cyc("b4_end");
    chk("b4.switch", 32'(bus.hgrant_vec_o), HOLD_EN ? 32'h1 : 32'h2);

    // 5: locked owner keeps the bus, one transfer after unlock
    drive(1'b1, T_IDLE, 3'b001, 3'b001);
    cyc("lk_req");
    chk("lk.grant", 32'(bus.hgrant_vec_o), 32'h1);
    drive(1'b1, T_NSEQ, 3'b011, 3'b001);
    for (int j = 0; j < 10; j++) begin
      cyc("lk_hold");
      chk("lk.hold", 32'(bus.hgrant_vec_o), 32'h1);
      chk("lk.mastlock", 32'(bus.hmastlock_o), 32'h1);
    end
    drive(1'b1, T_NSEQ, 3'b011, 3'b000);
    cyc("lk_rel");
    chk("lk.release", 32'(bus.hgrant_vec_o), 32'h2);
    chk("lk.mastlock_off", 32'(bus.hmastlock_o), 32'h0);

    // 6a: wait states freeze everything
    drive(1'b0, T_NSEQ, 3'b101, 3'b000);
    for (int j = 0; j < 5; j++) begin
      cyc("frz");
      chk("frz.grant", 32'(bus.hgrant_vec_o), 32'h2);
      chk("frz.hmaster", 32'(bus.hmaster_o), 32'h0);
    end
    drive(1'b1, T_NSEQ, 3'b101, 3'b000);
    cyc("frz_go");
    chk("frz_go.grant", 32'(bus.hgrant_vec_o), 32'h4);
    chk("frz_go.hmaster", 32'(bus.hmaster_o), 32'h1);

    // 6b: asynchronous reset in the middle of a burst
    drive(1'b1, T_SEQ, 3'b100, 3'b000);
    cyc("mid");
    chk("mid.hdata", 32'(bus.hmaster_data_o), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("areset.grant",   32'(bus.hgrant_vec_o),   32'h1);
    chk("areset.hmaster", 32'(bus.hmaster_o),      32'h0);
    chk("areset.hdata",   32'(bus.hmaster_data_o), 32'h0);
    chk("areset.mlock",   32'(bus.hmastlock_o),    32'h0);
    drive(1'b1, T_IDLE, 3'b000, 3'b000);
    repeat (2) cyc("rst2");
    rst_n = 1'b1;

    // 6c: INCR16 from M0 with M1 waiting; beat limit cuts it after 4 beats when enabled
    drive(1'b1, T_IDLE, 3'b001, 3'b000);
    cyc("h16_req");
    drive(1'b1, T_NSEQ, 3'b001, 3'b000);
    cyc("h16_b1");
    drive(1'b1, T_SEQ, 3'b011, 3'b000);
    cyc("h16_b2");
    cyc("h16_b3");
    chk("h16.beat3", 32'(bus.hgrant_vec_o), 32'h1);
    cyc("h16_b4");
    chk("h16.beat4", 32'(bus.hgrant_vec_o), HOLD_EN ? 32'h2 : 32'h1);
    repeat (12) cyc("h16_rest");
    drive(1'b1, T_IDLE, 3'b011, 3'b000);
    cyc("h16_end");

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            MC'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? MC'($urandom_range(0, 7)) : '0);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
